// File: rtl/spi_slave_axis_egress_sync_if.sv
// Byte stream from the readout egress FIFO into the SPI egress serialiser.
// The idle-fill byte (tuser) travels with the stream.
interface spi_slave_axis_egress_sync_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tuser;

  modport master (output tdata, tvalid, tuser, input tready);
  modport slave  (input tdata, tvalid, tuser, output tready);
endinterface

// File: rtl/spi_slave_axis_egress_sync.sv
// SPI slave egress in the system clock domain: oversamples spi_clk/spi_csn and
// shifts stream bytes (or the idle-fill byte) out on a 1/2/4-lane MISO bus.
module spi_slave_axis_egress_sync #(
  parameter int unsigned MISO_SIZE   = 1,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_clk,
  input  logic                          spi_csn,
  output logic [MISO_SIZE-1:0]          spi_miso,
  output logic                          spi_miso_oe,
  spi_slave_axis_egress_sync_if.slave   s_axis,
  input  logic                          clear_counters,
  output logic                          frame_active,
  output logic [15:0]                   bytes_sent,
  output logic [15:0]                   idle_bytes
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_ACTIVE} state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic               clk_d;
  logic               csn_d;
  logic [BYTE_W-1:0]  shreg;
  logic [BIT_W-1:0]   bitcnt;
  logic               first;
  logic               pop;
  logic [CNT_W-1:0]   sent_cnt;
  logic [CNT_W-1:0]   idle_cnt;

  logic               clk_s_c;
  logic               csn_s_c;
  logic               csn_fall_c;
  logic               csn_rise_c;
  logic               launch_c;
  logic               adv_c;
  logic               do_load_c;
  logic               do_shift_c;
  logic [BIT_W-1:0]   bitcnt_next_c;
  logic [BYTE_W-1:0]  load_byte_c;
  logic [BYTE_W-1:0]  shifted_c;

  assign bytes_sent = sent_cnt;
  assign idle_bytes = idle_cnt;

  // Edge decode on the synchronised pins; a csn rise masks any same-cycle launch.
  always_comb begin
    clk_s_c       = clk_sync[SYNC_STAGES-1];
    csn_s_c       = csn_sync[SYNC_STAGES-1];
    csn_fall_c    = csn_d & ~csn_s_c;
    csn_rise_c    = ~csn_d & csn_s_c;
    launch_c      = (CPHA != 0) ? ((clk_d == 1'(CPOL)) && (clk_s_c != 1'(CPOL)))
                                : ((clk_d != 1'(CPOL)) && (clk_s_c == 1'(CPOL)));
    bitcnt_next_c = bitcnt + BIT_W'(MISO_SIZE);
    load_byte_c   = s_axis.tvalid ? s_axis.tdata : s_axis.tuser;
    shifted_c     = (MSB_FIRST != 0) ? (shreg << MISO_SIZE) : (shreg >> MISO_SIZE);
    adv_c         = (state == S_ACTIVE) && !csn_rise_c && launch_c && !first;
    do_load_c     = ((state == S_IDLE) && csn_fall_c) || (adv_c && (bitcnt_next_c == '0));
    do_shift_c    = adv_c && (bitcnt_next_c != '0);
  end

  // csn synchroniser resets low so a frame already running at reset keeps WAIT parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync     <= {SYNC_STAGES{1'(CPOL)}};
      csn_sync     <= '0;
      clk_d        <= 1'(CPOL);
      csn_d        <= 1'b0;
      state        <= S_WAIT;
      shreg        <= '0;
      bitcnt       <= '0;
      first        <= 1'b0;
      pop          <= 1'b0;
      sent_cnt     <= '0;
      idle_cnt     <= '0;
      spi_miso     <= '0;
      spi_miso_oe  <= 1'b0;
      frame_active <= 1'b0;
      s_axis.tready <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      clk_d    <= clk_s_c;
      csn_d    <= csn_s_c;

      unique case (state)
        S_WAIT: if (csn_s_c) state <= S_IDLE;
        S_IDLE: begin
          if (csn_fall_c) begin
            state  <= S_ACTIVE;
            bitcnt <= '0;
            first  <= 1'(CPHA);
          end
        end
        S_ACTIVE: begin
          if (csn_rise_c) begin
            state <= S_IDLE;
          end else if (launch_c) begin
            if (first) first  <= 1'b0;
            else       bitcnt <= bitcnt_next_c;
          end
        end
        default: state <= S_WAIT;
      endcase

      if (do_load_c)       shreg <= load_byte_c;
      else if (do_shift_c) shreg <= shifted_c;
      pop <= do_load_c && s_axis.tvalid;

      if (clear_counters) begin
        sent_cnt <= '0;
        idle_cnt <= '0;
      end else if (do_load_c) begin
        if (s_axis.tvalid) begin
          if (sent_cnt != '1) sent_cnt <= sent_cnt + CNT_W'(1);
        end else if (idle_cnt != '1) begin
          idle_cnt <= idle_cnt + CNT_W'(1);
        end
      end

      // Output stage: one flop after the shifter so every pin reacts with equal latency.
      spi_miso      <= (MSB_FIRST != 0) ? shreg[BYTE_W-1 -: MISO_SIZE] : shreg[MISO_SIZE-1:0];
      spi_miso_oe   <= (state == S_ACTIVE);
      frame_active  <= (state == S_ACTIVE);
      s_axis.tready <= pop;
    end
  end
endmodule

// File: tb/tb_spi_slave_axis_egress_sync.sv
// Directed bench: three egress instances (mode0 x1 MSB, mode1 x2 LSB, mode3 x4 MSB)
// driven by a behavioural SPI master.
module tb_spi_slave_axis_egress_sync;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic spi_clk [3];
  logic spi_csn [3];
  logic clr [3];

  logic [0:0]  miso_a;
  logic [1:0]  miso_b;
  logic [3:0]  miso_c;
  logic        oe_a, oe_b, oe_c, fa_a, fa_b, fa_c;
  logic [15:0] bs_a, bs_b, bs_c, ib_a, ib_b, ib_c;

  spi_slave_axis_egress_sync_if axis_a ();
  spi_slave_axis_egress_sync_if axis_b ();
  spi_slave_axis_egress_sync_if axis_c ();

  spi_slave_axis_egress_sync #(.MISO_SIZE(1), .MSB_FIRST(1), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .spi_clk(spi_clk[0]), .spi_csn(spi_csn[0]), .spi_miso(miso_a),
    .spi_miso_oe(oe_a), .s_axis(axis_a.slave), .clear_counters(clr[0]), .frame_active(fa_a),
    .bytes_sent(bs_a), .idle_bytes(ib_a));

  spi_slave_axis_egress_sync #(.MISO_SIZE(2), .MSB_FIRST(0), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .spi_clk(spi_clk[1]), .spi_csn(spi_csn[1]), .spi_miso(miso_b),
    .spi_miso_oe(oe_b), .s_axis(axis_b.slave), .clear_counters(clr[1]), .frame_active(fa_b),
    .bytes_sent(bs_b), .idle_bytes(ib_b));

  spi_slave_axis_egress_sync #(.MISO_SIZE(4), .MSB_FIRST(1), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .reset(reset), .spi_clk(spi_clk[2]), .spi_csn(spi_csn[2]), .spi_miso(miso_c),
    .spi_miso_oe(oe_c), .s_axis(axis_c.slave), .clear_counters(clr[2]), .frame_active(fa_c),
    .bytes_sent(bs_c), .idle_bytes(ib_c));

  // FIFO source model for instance a: pops on tready while valid
  logic [7:0] fifo [16];
  logic [3:0] head = '0;
  logic [3:0] tail = '0;
  assign axis_a.tvalid = (head != tail);
  assign axis_a.tdata  = fifo[head];
  always @(posedge clk) if (axis_a.tready && axis_a.tvalid) head <= head + 4'd1;

  int rdy_a = 0, rdy_b = 0, rdy_c = 0, bad_rdy = 0;
  always @(posedge clk) begin
    if (axis_a.tready) rdy_a <= rdy_a + 1;
    if (axis_b.tready) rdy_b <= rdy_b + 1;
    if (axis_c.tready) rdy_c <= rdy_c + 1;
    if ((axis_a.tready && !axis_a.tvalid) || (axis_b.tready && !axis_b.tvalid) ||
        (axis_c.tready && !axis_c.tvalid))
      bad_rdy <= bad_rdy + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [3:0] rx [32];
  int rx_n;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    fifo[tail] = b;
    tail = tail + 4'd1;
  endtask

  function automatic logic [3:0] get_miso(input int idx);
    case (idx)
      0:       return {3'b000, miso_a};
      1:       return {2'b00, miso_b};
      default: return miso_c;
    endcase
  endfunction

  function automatic logic [7:0] rx_byte(input int base);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b = {b[6:0], rx[base+k][0]};
    return b;
  endfunction

  // SPI master: samples MISO just before its sampling edge
  task automatic spi_xfer(input int idx, input int ncyc, input bit cpol, input bit cpha, input bit raise);
    rx_n = 0;
    spi_csn[idx] = 1'b0;
    wait_clk(H);
    for (int i = 0; i < ncyc; i++) begin
      if (!cpha) begin rx[rx_n] = get_miso(idx); rx_n++; end
      spi_clk[idx] = ~cpol;
      wait_clk(H);
      if (cpha) begin rx[rx_n] = get_miso(idx); rx_n++; end
      spi_clk[idx] = cpol;
      wait_clk(H);
    end
    if (raise) begin
      spi_csn[idx] = 1'b1;
      wait_clk(H);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clk(4);
    checks++; if (miso_a !== 1'b0)  begin errors++; $display("FAIL reset_miso_a: got %h want 0", miso_a); end
    checks++; if (oe_a !== 1'b0)    begin errors++; $display("FAIL reset_oe_a: got %b want 0", oe_a); end
    checks++; if (axis_a.tready !== 1'b0) begin errors++; $display("FAIL reset_tready_a: got %b want 0", axis_a.tready); end
    checks++; if (fa_a !== 1'b0)    begin errors++; $display("FAIL reset_frame_active_a: got %b want 0", fa_a); end
    checks++; if (bs_a !== 16'd0)   begin errors++; $display("FAIL reset_bytes_sent_a: got %h want 0", bs_a); end
    checks++; if (ib_a !== 16'd0)   begin errors++; $display("FAIL reset_idle_bytes_a: got %h want 0", ib_a); end
    checks++; if ({miso_c, oe_c, fa_c, oe_b, fa_b} !== 8'h00) begin errors++; $display("FAIL reset_bc_outputs: got %h want 00", {miso_c, oe_c, fa_c, oe_b, fa_b}); end
    reset = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_mode0_stream;
    push(8'hA5);
    push(8'h3C);
    spi_xfer(0, 16, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_byte(0) !== 8'hA5) begin errors++; $display("FAIL mode0_byte0: got %h want a5", rx_byte(0)); end
    checks++; if (rx_byte(8) !== 8'h3C) begin errors++; $display("FAIL mode0_byte1: got %h want 3c", rx_byte(8)); end
    checks++; if (rdy_a !== 2)     begin errors++; $display("FAIL mode0_tready_pulses: got %0d want 2", rdy_a); end
    checks++; if (bs_a !== 16'd2)  begin errors++; $display("FAIL mode0_bytes_sent: got %0d want 2", bs_a); end
    checks++; if (ib_a !== 16'd1)  begin errors++; $display("FAIL mode0_idle_bytes: got %0d want 1", ib_a); end
    checks++; if (oe_a !== 1'b0)   begin errors++; $display("FAIL mode0_oe_after: got %b want 0", oe_a); end
  endtask

  task automatic test_lane2_lsb;
    axis_b.tdata  = 8'hE4;
    axis_b.tvalid = 1'b1;
    spi_xfer(1, 4, 1'b0, 1'b1, 1'b1);
    axis_b.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k][1:0] !== 2'(k)) begin errors++; $display("FAIL lane2_pair%0d: got %b want %b", k, rx[k][1:0], 2'(k)); end
    end
    checks++; if (rdy_b !== 1)    begin errors++; $display("FAIL lane2_tready_pulses: got %0d want 1", rdy_b); end
    checks++; if (bs_b !== 16'd1) begin errors++; $display("FAIL lane2_bytes_sent: got %0d want 1", bs_b); end
    checks++; if (ib_b !== 16'd0) begin errors++; $display("FAIL lane2_idle_bytes: got %0d want 0", ib_b); end
  endtask

  task automatic test_lane4_idle;
    logic [3:0] exp_n [4];
    exp_n[0] = 4'h5; exp_n[1] = 4'hA; exp_n[2] = 4'h5; exp_n[3] = 4'hA;
    spi_xfer(2, 4, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[k] !== exp_n[k]) begin errors++; $display("FAIL lane4_nibble%0d: got %h want %h", k, rx[k], exp_n[k]); end
    end
    checks++; if (rdy_c !== 0)    begin errors++; $display("FAIL lane4_tready_pulses: got %0d want 0", rdy_c); end
    checks++; if (ib_c !== 16'd2) begin errors++; $display("FAIL lane4_idle_bytes: got %0d want 2", ib_c); end
    checks++; if (bs_c !== 16'd0) begin errors++; $display("FAIL lane4_bytes_sent: got %0d want 0", bs_c); end
    checks++; if (oe_c !== 1'b0)  begin errors++; $display("FAIL lane4_oe_after: got %b want 0", oe_c); end
  endtask

  task automatic test_abort;
    clr[0] = 1'b1;
    wait_clk(1);
    clr[0] = 1'b0;
    wait_clk(1);
    checks++; if ({bs_a, ib_a} !== 32'd0) begin errors++; $display("FAIL abort_clear: got %h want 0", {bs_a, ib_a}); end
    push(8'hFF);
    push(8'h81);
    spi_xfer(0, 3, 1'b0, 1'b0, 1'b0);
    checks++; if ({rx[0][0], rx[1][0], rx[2][0]} !== 3'b111) begin errors++; $display("FAIL abort_first_bits: got %b want 111", {rx[0][0], rx[1][0], rx[2][0]}); end
    checks++; if ({oe_a, fa_a} !== 2'b11) begin errors++; $display("FAIL abort_active: got %b want 11", {oe_a, fa_a}); end
    spi_csn[0] = 1'b1;
    wait_clk(H);
    checks++; if ({oe_a, fa_a} !== 2'b00) begin errors++; $display("FAIL abort_oe_drop: got %b want 00", {oe_a, fa_a}); end
    spi_xfer(0, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_byte(0) !== 8'h81) begin errors++; $display("FAIL abort_new_byte: got %h want 81", rx_byte(0)); end
    checks++; if (bs_a !== 16'd2) begin errors++; $display("FAIL abort_bytes_sent: got %0d want 2", bs_a); end
    checks++; if (ib_a !== 16'd1) begin errors++; $display("FAIL abort_idle_bytes: got %0d want 1", ib_a); end
  endtask

  task automatic test_reset_mid_frame;
    int r0;
    push(8'h42);
    spi_csn[0] = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 2; i++) begin
      spi_clk[0] = 1'b1; wait_clk(H);
      spi_clk[0] = 1'b0; wait_clk(H);
    end
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    r0 = rdy_a;
    push(8'h99);
    for (int i = 0; i < 4; i++) begin
      spi_clk[0] = 1'b1; wait_clk(H);
      spi_clk[0] = 1'b0; wait_clk(H);
    end
    checks++; if ({oe_a, fa_a} !== 2'b00) begin errors++; $display("FAIL rstmid_oe: got %b want 00", {oe_a, fa_a}); end
    checks++; if (rdy_a !== r0)   begin errors++; $display("FAIL rstmid_no_tready: got %0d want %0d", rdy_a, r0); end
    checks++; if (bs_a !== 16'd0) begin errors++; $display("FAIL rstmid_bytes_sent: got %0d want 0", bs_a); end
    spi_csn[0] = 1'b1;
    wait_clk(H);
    spi_xfer(0, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_byte(0) !== 8'h99) begin errors++; $display("FAIL rstmid_byte: got %h want 99", rx_byte(0)); end
    checks++; if (rdy_a !== r0 + 1) begin errors++; $display("FAIL rstmid_tready_after: got %0d want %0d", rdy_a, r0 + 1); end
    checks++; if (bs_a !== 16'd1)   begin errors++; $display("FAIL rstmid_bytes_after: got %0d want 1", bs_a); end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    force dut_c.idle_cnt = 16'hFFFE;
    @(negedge clk);
    release dut_c.idle_cnt;
    spi_xfer(2, 4, 1'b1, 1'b1, 1'b1);
    checks++; if (ib_c !== 16'hFFFF) begin errors++; $display("FAIL sat_idle_bytes: got %h want ffff", ib_c); end
    // Clear asserted only in the cycle the frame-start load lands
    spi_csn[2] = 1'b0;
    wait_clk(2);
    clr[2] = 1'b1;
    wait_clk(1);
    clr[2] = 1'b0;
    checks++; if (ib_c !== 16'h0000) begin errors++; $display("FAIL sat_clear_priority: got %h want 0000", ib_c); end
    wait_clk(H);
    spi_csn[2] = 1'b1;
    wait_clk(H);
    checks++; if ({ib_c, bs_c} !== 32'd0) begin errors++; $display("FAIL sat_after_clear: got %h want 0", {ib_c, bs_c}); end
  endtask

  initial begin
    spi_clk[0] = 1'b0; spi_clk[1] = 1'b0; spi_clk[2] = 1'b1;
    spi_csn[0] = 1'b1; spi_csn[1] = 1'b1; spi_csn[2] = 1'b1;
    clr[0] = 1'b0; clr[1] = 1'b0; clr[2] = 1'b0;
    reset = 1'b1;
    axis_a.tuser  = 8'h00;
    axis_b.tdata  = 8'h00;
    axis_b.tvalid = 1'b0;
    axis_b.tuser  = 8'h00;
    axis_c.tdata  = 8'h00;
    axis_c.tvalid = 1'b0;
    axis_c.tuser  = 8'h5A;

    test_reset();
    test_mode0_stream();
    test_lane2_lsb();
    test_lane4_idle();
    test_abort();
    test_reset_mid_frame();
    test_saturation();

    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL tready_without_tvalid: got %0d want 0", bad_rdy); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
